// File: rtl/capture_sequencer_pkg.sv
// capture_sequencer_pkg
//   Shared definitions for the segmented-capture sequencer: default widths and
//   the 3-bit FSM state encoding.
package capture_sequencer_pkg;

    localparam int unsigned SegWDefault  = 16;
    localparam int unsigned AddrWDefault = 30;
    localparam int unsigned TmoWDefault  = 32;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StArm      = 3'd1,
        StWaitTrig = 3'd2,
        StCapture  = 3'd3,
        StNext     = 3'd4,
        StDone     = 3'd5
    } seq_state_e;

endpackage

// File: rtl/capture_sequencer_if.sv
// capture_sequencer_if
//   Groups the host register signals and the trigger_unit / capture-stop
//   handshake of the segmented-capture sequencer.
//   Host side:    start_i, abort_i, num_segments_i, base_addr_i, seg_stride_i,
//                 timeout_i in; seg_addr_o, seg_count_o, busy_o, done_o,
//                 timeout_o, aborted_o out.
//   Trigger side: arm_o out; armed_i, capture_go_i, capture_done_i in.
//   Modports: slave = the sequencer, master = the surrounding environment.
interface capture_sequencer_if
    import capture_sequencer_pkg::*;
#(
    parameter int unsigned SEG_W  = SegWDefault,
    parameter int unsigned ADDR_W = AddrWDefault,
    parameter int unsigned TMO_W  = TmoWDefault
) ();

    logic              start_i;
    logic              abort_i;
    logic [SEG_W-1:0]  num_segments_i;
    logic [ADDR_W-1:0] base_addr_i;
    logic [ADDR_W-1:0] seg_stride_i;
    logic [TMO_W-1:0]  timeout_i;
    logic              arm_o;
    logic              armed_i;
    logic              capture_go_i;
    logic              capture_done_i;
    logic [ADDR_W-1:0] seg_addr_o;
    logic [SEG_W-1:0]  seg_count_o;
    logic              busy_o;
    logic              done_o;
    logic              timeout_o;
    logic              aborted_o;

    modport slave (
        input  start_i, abort_i, num_segments_i, base_addr_i, seg_stride_i, timeout_i,
        input  armed_i, capture_go_i, capture_done_i,
        output arm_o, seg_addr_o, seg_count_o, busy_o, done_o, timeout_o, aborted_o
    );

    modport master (
        output start_i, abort_i, num_segments_i, base_addr_i, seg_stride_i, timeout_i,
        output armed_i, capture_go_i, capture_done_i,
        input  arm_o, seg_addr_o, seg_count_o, busy_o, done_o, timeout_o, aborted_o
    );

endinterface

// File: rtl/seq_timeout_timer.sv
// seq_timeout_timer
//   Loadable down-counter guarding the arm-to-trigger wait of one segment.
//   clk, reset   : clock, asynchronous active-high reset
//   i_load       : load i_load_val (takes priority over counting)
//   i_load_val   : timeout in cycles; 0 disables the timer
//   i_en         : decrement this cycle
//   o_zero       : the decrement in this cycle brings the count to zero
//   o_disabled   : last load value was 0 (wait forever)
module seq_timeout_timer #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_zero,
    output logic         o_disabled
);

    logic [W-1:0] r_count;
    logic         r_disabled;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count    <= '0;
            r_disabled <= 1'b1;
        end else if (i_load) begin
            r_count    <= i_load_val;
            r_disabled <= (i_load_val == '0);
        end else if (i_en && !r_disabled && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    // Flag the final decrement so the FSM acts on the same edge the count hits 0.
    assign o_zero     = i_en && (r_count == W'(1));
    assign o_disabled = r_disabled;

endmodule

// File: rtl/capture_sequencer.sv
// capture_sequencer
//   Segmented-capture controller: repeatedly arms the trigger unit, waits for
//   each capture to finish and steps the DDR write base by a fixed stride so
//   N captures land back-to-back in memory.
//   clk, reset : system clock, asynchronous active-high reset
//   seq_if     : capture_sequencer_if.slave (host parameters/status and the
//                trigger_unit / capture-stop handshake)
module capture_sequencer
    import capture_sequencer_pkg::*;
#(
    parameter int unsigned SEG_W  = SegWDefault,
    parameter int unsigned ADDR_W = AddrWDefault,
    parameter int unsigned TMO_W  = TmoWDefault
) (
    input logic                clk,
    input logic                reset,
    capture_sequencer_if.slave seq_if
);

    seq_state_e        r_state;
    logic              r_arm;
    logic [ADDR_W-1:0] r_seg_addr;
    logic [SEG_W-1:0]  r_seg_count;
    logic              r_busy;
    logic              r_done;
    logic              r_timeout;
    logic              r_aborted;
    logic [SEG_W-1:0]  r_num_seg;
    logic [ADDR_W-1:0] r_stride;
    logic [TMO_W-1:0]  r_tmo;

    seq_state_e        w_state_d;
    logic              w_arm_d;
    logic [ADDR_W-1:0] w_seg_addr_d;
    logic [SEG_W-1:0]  w_seg_count_d;
    logic              w_busy_d;
    logic              w_done_d;
    logic              w_timeout_d;
    logic              w_aborted_d;
    logic              w_latch;
    logic              w_tmr_load;
    logic [TMO_W-1:0]  w_tmr_load_val;
    logic              w_tmr_en;
    logic              w_tmr_zero;
    logic              w_tmr_disabled;
    logic              w_expire;
    logic              w_cap_idle;
    logic [SEG_W-1:0]  w_count_inc;

    seq_timeout_timer #(
        .W (TMO_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_load_val),
        .i_en       (w_tmr_en),
        .o_zero     (w_tmr_zero),
        .o_disabled (w_tmr_disabled)
    );

    assign w_expire    = w_tmr_zero && !w_tmr_disabled;
    assign w_cap_idle  = !seq_if.capture_go_i && !seq_if.capture_done_i;
    assign w_count_inc = r_seg_count + 1'b1;

    always_comb begin
        w_state_d      = r_state;
        w_arm_d        = r_arm;
        w_seg_addr_d   = r_seg_addr;
        w_seg_count_d  = r_seg_count;
        w_busy_d       = r_busy;
        // done_o trails the DONE state by one cycle; busy_o holds through it.
        w_done_d       = (r_state == StDone);
        w_timeout_d    = r_timeout;
        w_aborted_d    = r_aborted;
        w_latch        = 1'b0;
        w_tmr_load     = 1'b0;
        w_tmr_load_val = r_tmo;
        w_tmr_en       = 1'b0;

        unique case (r_state)
            StIdle: begin
                w_arm_d  = 1'b0;
                w_busy_d = 1'b0;
                if (seq_if.start_i && !seq_if.abort_i) begin
                    w_state_d      = StArm;
                    w_latch        = 1'b1;
                    w_seg_count_d  = '0;
                    w_seg_addr_d   = seq_if.base_addr_i;
                    w_busy_d       = 1'b1;
                    w_timeout_d    = 1'b0;
                    w_aborted_d    = 1'b0;
                    w_tmr_load     = 1'b1;
                    w_tmr_load_val = seq_if.timeout_i;
                    w_arm_d        = w_cap_idle;
                end
            end
            StArm: begin
                w_tmr_en = 1'b1;
                if (seq_if.abort_i) begin
                    w_aborted_d = 1'b1;
                    w_arm_d     = 1'b0;
                    w_state_d   = StDone;
                end else if (w_expire) begin
                    w_timeout_d = 1'b1;
                    w_arm_d     = 1'b0;
                    w_state_d   = StDone;
                end else if (r_arm && seq_if.armed_i) begin
                    w_arm_d   = 1'b1;
                    w_state_d = StWaitTrig;
                end else begin
                    // Raise arm only once the previous capture has fully released.
                    w_arm_d = r_arm || w_cap_idle;
                end
            end
            StWaitTrig: begin
                w_tmr_en = 1'b1;
                if (seq_if.abort_i) begin
                    w_aborted_d = 1'b1;
                    w_arm_d     = 1'b0;
                    w_state_d   = StDone;
                end else if (w_expire) begin
                    w_timeout_d = 1'b1;
                    w_arm_d     = 1'b0;
                    w_state_d   = StDone;
                end else if (seq_if.capture_go_i) begin
                    w_arm_d   = 1'b0;
                    w_state_d = StCapture;
                end else begin
                    w_arm_d = 1'b1;
                end
            end
            StCapture: begin
                w_arm_d = 1'b0;
                if (seq_if.abort_i) begin
                    w_aborted_d = 1'b1;
                    w_state_d   = StDone;
                end else if (seq_if.capture_done_i) begin
                    w_state_d = StNext;
                end
            end
            StNext: begin
                w_arm_d = 1'b0;
                if (seq_if.abort_i) begin
                    w_aborted_d = 1'b1;
                    w_state_d   = StDone;
                end else begin
                    w_seg_count_d = w_count_inc;
                    w_seg_addr_d  = r_seg_addr + r_stride;
                    if (w_count_inc == r_num_seg) begin
                        w_state_d = StDone;
                    end else begin
                        w_state_d  = StArm;
                        w_tmr_load = 1'b1;
                    end
                end
            end
            StDone: begin
                w_arm_d   = 1'b0;
                w_state_d = StIdle;
            end
            default: begin
                w_arm_d   = 1'b0;
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_arm       <= 1'b0;
            r_seg_addr  <= '0;
            r_seg_count <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_aborted   <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_arm       <= w_arm_d;
            r_seg_addr  <= w_seg_addr_d;
            r_seg_count <= w_seg_count_d;
            r_busy      <= w_busy_d;
            r_done      <= w_done_d;
            r_timeout   <= w_timeout_d;
            r_aborted   <= w_aborted_d;
        end
    end

    // Parameters are captured once per sequence; a count of 0 means one segment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_num_seg <= '0;
            r_stride  <= '0;
            r_tmo     <= '0;
        end else if (w_latch) begin
            r_num_seg <= (seq_if.num_segments_i == '0) ? SEG_W'(1) : seq_if.num_segments_i;
            r_stride  <= seq_if.seg_stride_i;
            r_tmo     <= seq_if.timeout_i;
        end
    end

    assign seq_if.arm_o       = r_arm;
    assign seq_if.seg_addr_o  = r_seg_addr;
    assign seq_if.seg_count_o = r_seg_count;
    assign seq_if.busy_o      = r_busy;
    assign seq_if.done_o      = r_done;
    assign seq_if.timeout_o   = r_timeout;
    assign seq_if.aborted_o   = r_aborted;

endmodule
